// File: rtl/sdrc_bist_pkg.sv
// Shared types, sizes and pattern function for the SDRAM controller BIST master.
// The expected-word function is the single source of truth for write and compare data.
package sdrc_bist_pkg;

    localparam int APP_AW    = 26;
    localparam int APP_DW    = 32;
    localparam int APP_BW    = 4;
    localparam int BL        = 9;
    localparam int BURST_LEN = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_WR_REQ,
        S_WR_DATA,
        S_RD_REQ,
        S_RD_DATA,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PAT_ADDR  = 2'b00,
        PAT_WALK  = 2'b01,
        PAT_CHK   = 2'b10,
        PAT_NADDR = 2'b11
    } pat_t;

    function automatic logic [APP_DW-1:0] pat_word(
        input logic [1:0]        sel,
        input logic [APP_AW-1:0] base,
        input logic [APP_AW-1:0] w
    );
        logic [APP_AW-1:0] a;
        logic [APP_DW-1:0] r;
        a = base + w;
        r = '0;
        unique case (sel)
            PAT_ADDR:  r = {{(APP_DW-APP_AW){1'b0}}, a};
            PAT_WALK:  r = 32'h1 << w[4:0];
            PAT_CHK:   r = w[0] ? 32'hAAAA5555 : 32'h5555AAAA;
            PAT_NADDR: r = ~{{(APP_DW-APP_AW){1'b0}}, a};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sdrc_bist_patgen.sv
// Registered pattern word: the write word in the write phase,
// the expected word in the read phase.
module sdrc_bist_patgen
    import sdrc_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [1:0]        sel,
    input  logic [APP_AW-1:0] base,
    input  logic [APP_AW-1:0] w,
    output logic [APP_DW-1:0] word
);

    logic [APP_DW-1:0] word_q;
    logic [APP_DW-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (ld) begin
            word_d = pat_word(sel, base, w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/sdrc_bist_master.sv
// BIST initiator for the sdrc_core app port: writes a pattern in bursts,
// reads it back, compares every word and reports the result.
module sdrc_bist_master
    import sdrc_bist_pkg::*;
(
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_init_done,
    input  logic              bist_start,
    input  logic [APP_AW-1:0] bist_base_addr,
    input  logic [7:0]        bist_num_bursts,
    input  logic [1:0]        bist_pattern_sel,
    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [BL-1:0]     app_req_len,
    output logic              app_req_wr_n,
    input  logic              app_req_ack,
    output logic [APP_DW-1:0] app_wr_data,
    output logic [APP_BW-1:0] app_wr_en_n,
    input  logic              app_wr_next_req,
    input  logic              app_rd_valid,
    input  logic [APP_DW-1:0] app_rd_data,
    input  logic              app_last_rd,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic [15:0]       bist_err_cnt,
    output logic [APP_AW-1:0] bist_first_err_addr
);

    localparam logic [APP_AW-1:0] BLEN_W = APP_AW'(BURST_LEN);
    localparam logic [BL-1:0]     BLEN_B = BL'(BURST_LEN);

    state_t            state_q, state_d;
    logic [APP_AW-1:0] base_q, base_d;
    logic [7:0]        nb_q, nb_d;
    logic [1:0]        sel_q, sel_d;
    logic [7:0]        burst_q, burst_d;
    logic [BL-1:0]     beat_q, beat_d;
    logic              req_q, req_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic              wr_n_q, wr_n_d;
    logic [APP_BW-1:0] en_n_q, en_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [APP_AW-1:0] ferr_q, ferr_d;

    logic              cmp_vld_q, cmp_vld_d;
    logic [APP_DW-1:0] cmp_data_q, cmp_data_d;
    logic [APP_DW-1:0] cmp_exp_q, cmp_exp_d;
    logic [APP_AW-1:0] cmp_addr_q, cmp_addr_d;
    logic              len_err_q, len_err_d;
    logic [APP_AW-1:0] len_addr_q, len_addr_d;

    logic              pg_ld;
    logic [APP_AW-1:0] pg_w;
    logic [APP_DW-1:0] word;

    logic [7:0]        burst_nxt;
    logic              last_burst;
    logic              last_beat;
    logic [APP_AW-1:0] w_b;
    logic [APP_AW-1:0] w_cur;
    logic [APP_AW-1:0] w_nb;
    logic [BL-1:0]     rd_cnt;
    logic              start_ok;
    logic              mis;
    logic [16:0]       sum;

    assign burst_nxt  = burst_q + 8'd1;
    assign last_burst = (burst_nxt == nb_q);
    assign last_beat  = (beat_q == BLEN_B - BL'(1));
    assign w_b        = APP_AW'(burst_q) * BLEN_W;
    assign w_cur      = w_b + APP_AW'(beat_q);
    assign w_nb       = APP_AW'(burst_nxt) * BLEN_W;
    assign rd_cnt     = beat_q + {{(BL-1){1'b0}}, app_rd_valid};
    assign start_ok   = bist_start && !busy_q &&
                        (state_q == S_IDLE || state_q == S_DONE);

    sdrc_bist_patgen u_patgen (
        .clk   (sdram_clk),
        .rst_n (sdram_resetn),
        .ld    (pg_ld),
        .sel   (sel_q),
        .base  (base_q),
        .w     (pg_w),
        .word  (word)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        nb_d       = nb_q;
        sel_d      = sel_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wr_n_d     = wr_n_q;
        en_n_d     = en_n_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        ferr_d     = ferr_q;
        cmp_vld_d  = 1'b0;
        cmp_data_d = cmp_data_q;
        cmp_exp_d  = cmp_exp_q;
        cmp_addr_d = cmp_addr_q;
        len_err_d  = 1'b0;
        len_addr_d = len_addr_q;
        pg_ld      = 1'b0;
        pg_w       = w_cur;

        // Compare stage: up to two errors may land in one cycle.
        mis   = cmp_vld_q && (cmp_data_q != cmp_exp_q);
        sum   = {1'b0, err_q} + {16'b0, mis} + {16'b0, len_err_q};
        err_d = sum[16] ? 16'hFFFF : sum[15:0];
        if (err_q == '0 && (mis || len_err_q)) begin
            ferr_d = mis ? cmp_addr_q : len_addr_q;
        end

        unique case (state_q)
            S_IDLE: ;
            S_WAIT_INIT: begin
                if (sdr_init_done) begin
                    state_d = S_WR_REQ;
                    req_d   = 1'b1;
                    wr_n_d  = 1'b0;
                    addr_d  = base_q;
                    en_n_d  = '0;
                    pg_ld   = 1'b1;
                    pg_w    = '0;
                end
            end
            S_WR_REQ: begin
                if (app_req_ack) begin
                    state_d = S_WR_DATA;
                    req_d   = 1'b0;
                end
            end
            S_WR_DATA: begin
                if (app_wr_next_req) begin
                    pg_ld = 1'b1;
                    if (!last_beat) begin
                        beat_d = beat_q + BL'(1);
                        pg_w   = w_cur + APP_AW'(1);
                    end else if (!last_burst) begin
                        beat_d  = '0;
                        burst_d = burst_nxt;
                        state_d = S_WR_REQ;
                        req_d   = 1'b1;
                        addr_d  = base_q + w_nb;
                        pg_w    = w_nb;
                    end else begin
                        beat_d  = '0;
                        burst_d = '0;
                        state_d = S_RD_REQ;
                        req_d   = 1'b1;
                        wr_n_d  = 1'b1;
                        addr_d  = base_q;
                        en_n_d  = '1;
                        pg_w    = '0;
                    end
                end
            end
            S_RD_REQ: begin
                if (app_req_ack) begin
                    state_d = S_RD_DATA;
                    req_d   = 1'b0;
                end
            end
            S_RD_DATA: begin
                if (app_rd_valid) begin
                    cmp_vld_d  = 1'b1;
                    cmp_data_d = app_rd_data;
                    cmp_exp_d  = word;
                    cmp_addr_d = base_q + w_cur;
                    beat_d     = beat_q + BL'(1);
                    pg_ld      = 1'b1;
                    pg_w       = w_cur + APP_AW'(1);
                end
                if (app_last_rd) begin
                    len_err_d  = (rd_cnt != BLEN_B);
                    len_addr_d = base_q + w_b;
                    beat_d     = '0;
                    if (!last_burst) begin
                        burst_d = burst_nxt;
                        state_d = S_RD_REQ;
                        req_d   = 1'b1;
                        addr_d  = base_q + w_nb;
                        pg_ld   = 1'b1;
                        pg_w    = w_nb;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_d == '0);
            end
            default: state_d = S_IDLE;
        endcase

        if (start_ok) begin
            base_d  = bist_base_addr;
            nb_d    = bist_num_bursts;
            sel_d   = bist_pattern_sel;
            burst_d = '0;
            beat_d  = '0;
            err_d   = '0;
            ferr_d  = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = (bist_num_bursts == 8'd0) ? S_DONE : S_WAIT_INIT;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            nb_q       <= '0;
            sel_q      <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wr_n_q     <= 1'b1;
            en_n_q     <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ferr_q     <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_data_q <= '0;
            cmp_exp_q  <= '0;
            cmp_addr_q <= '0;
            len_err_q  <= 1'b0;
            len_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nb_q       <= nb_d;
            sel_q      <= sel_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wr_n_q     <= wr_n_d;
            en_n_q     <= en_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_data_q <= cmp_data_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_addr_q <= cmp_addr_d;
            len_err_q  <= len_err_d;
            len_addr_q <= len_addr_d;
        end
    end

    assign app_req             = req_q;
    assign app_req_addr        = addr_q;
    assign app_req_len         = BLEN_B;
    assign app_req_wr_n        = wr_n_q;
    assign app_wr_data         = word;
    assign app_wr_en_n         = en_n_q;
    assign bist_busy           = busy_q;
    assign bist_done           = done_q;
    assign bist_pass           = pass_q;
    assign bist_err_cnt        = err_q;
    assign bist_first_err_addr = ferr_q;

endmodule

// File: tb/tb_sdrc_bist_master.sv
// Directed bench for sdrc_bist_master with a behavioural app-port memory
// and scoreboard queues for requests and write words.
module tb_sdrc_bist_master;

    logic        clk;
    logic        rst_n;
    logic        sdr_init_done;
    logic        bist_start;
    logic [25:0] bist_base_addr;
    logic [7:0]  bist_num_bursts;
    logic [1:0]  bist_pattern_sel;
    logic        app_req;
    logic [25:0] app_req_addr;
    logic [8:0]  app_req_len;
    logic        app_req_wr_n;
    logic        app_req_ack;
    logic [31:0] app_wr_data;
    logic [3:0]  app_wr_en_n;
    logic        app_wr_next_req;
    logic        app_rd_valid;
    logic [31:0] app_rd_data;
    logic        app_last_rd;
    logic        bist_busy;
    logic        bist_done;
    logic        bist_pass;
    logic [15:0] bist_err_cnt;
    logic [25:0] bist_first_err_addr;

    sdrc_bist_master dut (
        .sdram_clk           (clk),
        .sdram_resetn        (rst_n),
        .sdr_init_done       (sdr_init_done),
        .bist_start          (bist_start),
        .bist_base_addr      (bist_base_addr),
        .bist_num_bursts     (bist_num_bursts),
        .bist_pattern_sel    (bist_pattern_sel),
        .app_req             (app_req),
        .app_req_addr        (app_req_addr),
        .app_req_len         (app_req_len),
        .app_req_wr_n        (app_req_wr_n),
        .app_req_ack         (app_req_ack),
        .app_wr_data         (app_wr_data),
        .app_wr_en_n         (app_wr_en_n),
        .app_wr_next_req     (app_wr_next_req),
        .app_rd_valid        (app_rd_valid),
        .app_rd_data         (app_rd_data),
        .app_last_rd         (app_last_rd),
        .bist_busy           (bist_busy),
        .bist_done           (bist_done),
        .bist_pass           (bist_pass),
        .bist_err_cnt        (bist_err_cnt),
        .bist_first_err_addr (bist_first_err_addr)
    );

    localparam int BLEN = 8;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [26:0] rq[$];
    logic [31:0] wq[$];
    logic [31:0] mem[int];

    int ack_delay   = 0;
    int wr_gap      = 0;
    int corrupt     = -1;
    int req_cnt     = 0;
    int last_rd_cyc = 0;

    int          m_st   = 0;
    int          m_cnt  = 0;
    int          m_beat = 0;
    int          m_gap  = 0;
    logic [25:0] sv_addr;
    logic        sv_wrn;
    logic [31:0] sv_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [1:0] s,
                                             input logic [25:0] b,
                                             input int w);
        logic [25:0] a;
        a = b + 26'(w);
        case (s)
            2'd0: return {6'b0, a};
            2'd1: return 32'h1 << (w % 32);
            2'd2: return (w % 2 == 0) ? 32'h5555AAAA : 32'hAAAA5555;
            default: return ~{6'b0, a};
        endcase
    endfunction

    // App-port memory model, driven on the falling edge.
    always @(negedge clk) begin
        app_req_ack     = 1'b0;
        app_wr_next_req = 1'b0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
        app_rd_data     = '0;
        if (!rst_n) begin
            m_st = 0;
        end else begin
            if (app_req) req_cnt++;
            if (m_st == 0 && app_req) begin
                sv_addr = app_req_addr;
                sv_wrn  = app_req_wr_n;
                sv_data = app_wr_data;
                m_cnt   = 0;
                m_st    = 1;
                check("req_avail", 64'(rq.size() > 0), 1);
                if (rq.size() > 0) check("req_addr_wrn", {app_req_wr_n, app_req_addr}, rq.pop_front());
                if (!app_req_wr_n && wq.size() > 0) check("first_word", app_wr_data, wq[0]);
            end
            if (m_st == 1) begin
                check("req_hold", app_req, 1);
                check("addr_hold", app_req_addr, sv_addr);
                check("wrn_hold", app_req_wr_n, sv_wrn);
                if (!sv_wrn) check("data_hold", app_wr_data, sv_data);
                if (m_cnt == ack_delay) begin
                    app_req_ack = 1'b1;
                    m_st   = sv_wrn ? 3 : 2;
                    m_beat = 0;
                    m_gap  = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_st == 2) begin
                if (m_gap < wr_gap) begin
                    m_gap++;
                end else begin
                    m_gap = 0;
                    app_wr_next_req = 1'b1;
                    check("en_n_wr", app_wr_en_n, 4'h0);
                    check("wq_avail", 64'(wq.size() > 0), 1);
                    if (wq.size() > 0) check("wr_word", app_wr_data, wq.pop_front());
                    mem[int'(sv_addr) + m_beat] = app_wr_data;
                    m_beat++;
                    if (m_beat == BLEN) m_st = 0;
                end
            end else if (m_st == 3) begin
                app_rd_valid = 1'b1;
                if (int'(sv_addr) + m_beat == corrupt)
                    app_rd_data = 32'h0;
                else if (mem.exists(int'(sv_addr) + m_beat))
                    app_rd_data = mem[int'(sv_addr) + m_beat];
                if (m_beat == BLEN - 1) begin
                    app_last_rd = 1'b1;
                    last_rd_cyc = cyc;
                    m_st = 0;
                end
                m_beat++;
            end
        end
    end

    task automatic start_test(input logic [25:0] b, input int n,
                              input logic [1:0] s);
        for (int i = 0; i < n; i++) rq.push_back({1'b0, b + 26'(i * BLEN)});
        for (int i = 0; i < n; i++) rq.push_back({1'b1, b + 26'(i * BLEN)});
        for (int w = 0; w < n * BLEN; w++) wq.push_back(exp_word(s, b, w));
        @(negedge clk);
        bist_base_addr   = b;
        bist_num_bursts  = 8'(n);
        bist_pattern_sel = s;
        bist_start       = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int dc);
        int i;
        i = 0;
        while (!bist_done && i < lim) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", bist_done, 1);
        dc = cyc;
    endtask

    task automatic chk_reset();
        check("rst_req", app_req, 0);
        check("rst_addr", app_req_addr, 0);
        check("rst_len", app_req_len, 9'd8);
        check("rst_wrn", app_req_wr_n, 1);
        check("rst_wdata", app_wr_data, 0);
        check("rst_en_n", app_wr_en_n, 4'hF);
        check("rst_busy", bist_busy, 0);
        check("rst_done", bist_done, 0);
        check("rst_pass", bist_pass, 0);
        check("rst_err", bist_err_cnt, 0);
        check("rst_ferr", bist_first_err_addr, 0);
    endtask

    task automatic chk_result(input logic p, input int e, input int fa);
        check("res_done", bist_done, 1);
        check("res_busy", bist_busy, 0);
        check("res_pass", bist_pass, p);
        check("res_err", bist_err_cnt, 64'(e));
        check("res_ferr", bist_first_err_addr, 64'(fa));
        check("rq_empty", rq.size(), 0);
        check("wq_empty", wq.size(), 0);
    endtask

    initial begin
        int dc;
        int rc;
        logic saw;
        rst_n            = 1'b0;
        sdr_init_done    = 1'b1;
        bist_start       = 1'b0;
        bist_base_addr   = '0;
        bist_num_bursts  = '0;
        bist_pattern_sel = '0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);

        // Address pattern, ideal memory, start-up latency.
        start_test(26'h100, 2, 2'b00);
        check("busy_lat", bist_busy, 1);
        check("req_early", app_req, 0);
        @(negedge clk);
        check("req_lat", app_req, 1);
        check("req_addr0", app_req_addr, 26'h100);
        check("wdata0", app_wr_data, 32'h100);
        check("en_n0", app_wr_en_n, 4'h0);
        wait_done(2000, dc);
        check("done_lat", 64'(dc - last_rd_cyc), 2);
        chk_result(1'b1, 0, 0);

        // Single corrupted word on read-back.
        corrupt = 26'h10A;
        start_test(26'h100, 2, 2'b00);
        wait_done(2000, dc);
        check("done_lat_b", 64'(dc - last_rd_cyc), 2);
        chk_result(1'b0, 1, 26'h10A);
        corrupt = -1;

        // Zero bursts: no requests, done quickly.
        rc = req_cnt;
        start_test(26'h200, 0, 2'b00);
        wait_done(2, dc);
        check("zero_req", req_cnt, rc);
        chk_result(1'b1, 0, 0);

        // Init held low.
        sdr_init_done = 1'b0;
        start_test(26'h400, 1, 2'b01);
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk);
            saw = saw | app_req;
        end
        check("init_hold", saw, 0);
        sdr_init_done = 1'b1;
        @(negedge clk);
        check("init_req", app_req, 1);
        wait_done(2000, dc);
        chk_result(1'b1, 0, 0);

        // Slow ack, gapped write strobes, checkerboard.
        ack_delay = 5;
        wr_gap    = 2;
        start_test(26'h2000, 2, 2'b10);
        wait_done(4000, dc);
        chk_result(1'b1, 0, 0);
        ack_delay = 0;
        wr_gap    = 1;

        // Reset in the middle of a write burst.
        start_test(26'h3000, 2, 2'b00);
        saw = 1'b0;
        for (int i = 0; i < 2000 && !saw; i++) begin
            @(negedge clk);
            saw = (m_st == 2 && m_beat == 3);
        end
        check("rst_trig", saw, 1);
        rst_n = 1'b0;
        #1;
        chk_reset();
        rq.delete();
        wq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr_gap = 0;
        @(negedge clk);
        start_test(26'h300, 1, 2'b11);
        wait_done(2000, dc);
        chk_result(1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
